// File: rtl/mapu_pkg.sv
// rtl/mapu_pkg.sv - shared types and constants for the MAPU row serializer
package mapu_pkg;

   // Widest matrix element any MAPU configuration produces
   localparam int MAPU_DATA_MAX_WIDTH = 32;

   // Matrix geometry: 3x3, emitted row by row
   localparam int ROWS_PER_MATRIX = 3;
   localparam int ELEMS_PER_ROW   = 3;

   // Index of the final element in a row and of the final row in a matrix
   localparam logic [1:0] LAST_ELEM = 2'(ELEMS_PER_ROW - 1);
   localparam logic [1:0] LAST_ROW  = 2'(ROWS_PER_MATRIX - 1);

   typedef logic [MAPU_DATA_MAX_WIDTH-1:0] mapu_elem_t;

   // One buffered MAPU output row together with its overflow flag
   typedef struct packed {
      mapu_elem_t r0;
      mapu_elem_t r1;
      mapu_elem_t r2;
      logic       of;
   } mapu_row_t;

   // Modulo counter step: idx advances and wraps to 0 after last
   function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input logic [1:0] last);
      return (idx == last) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/mapu_row_fifo.sv
// rtl/mapu_row_fifo.sv - two-entry row FIFO feeding the serializer
import mapu_pkg::*;

module mapu_row_fifo (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic       pop,
   input  mapu_row_t  wr_row,
   output mapu_row_t  head,
   output logic [1:0] count
);

   mapu_row_t mem [2];
   logic      wr_ptr;
   logic      rd_ptr;

   // Storage, pointers and occupancy; push and pop together keep count level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_row;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/mapu_row_ser.sv
// rtl/mapu_row_ser.sv - serializes 3-element MAPU rows into a 3x3 element stream
import mapu_pkg::*;

module mapu_row_ser #(
   parameter int DATA_WIDTH = MAPU_DATA_MAX_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_en,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_r0,
   input  logic [DATA_WIDTH-1:0] i_r1,
   input  logic [DATA_WIDTH-1:0] i_r2,
   input  logic                  i_of,
   output logic                  o_rdy,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_eor,
   output logic                  o_eom,
   output logic                  o_of,
   input  logic                  i_rdy
);

   mapu_row_t  wr_row;
   mapu_row_t  head;
   logic [1:0] count;
   logic [1:0] elem_idx;
   logic [1:0] row_idx;
   logic       ovf_acc;
   logic       accept;
   logic       take;
   logic       pop;
   mapu_elem_t sel_elem;

   // Rows are stored at full package width; narrower configs are zero-extended
   always_comb begin
      wr_row    = '0;
      wr_row.r0 = MAPU_DATA_MAX_WIDTH'(i_r0);
      wr_row.r1 = MAPU_DATA_MAX_WIDTH'(i_r1);
      wr_row.r2 = MAPU_DATA_MAX_WIDTH'(i_r2);
      wr_row.of = i_of;
   end

   // Ready depends only on registered occupancy, enable and reset
   assign o_rdy  = i_en & reset_n & (count < 2'd2);
   assign accept = i_vld & o_rdy;
   assign o_vld  = (count != 2'd0);
   assign take   = o_vld & i_rdy;
   assign pop    = take & (elem_idx == LAST_ELEM);

   mapu_row_fifo u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (accept),
      .pop     (pop),
      .wr_row  (wr_row),
      .head    (head),
      .count   (count)
   );

   // Element, row and overflow tracking advance only on handshakes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         elem_idx <= 2'd0;
         row_idx  <= 2'd0;
         ovf_acc  <= 1'b0;
      end else begin
         if (take) begin
            elem_idx <= wrap_inc(elem_idx, LAST_ELEM);
         end
         if (pop) begin
            row_idx <= wrap_inc(row_idx, LAST_ROW);
            // The final row's flag is folded in combinationally on the eom beat
            ovf_acc <= (row_idx == LAST_ROW) ? 1'b0 : (ovf_acc | head.of);
         end
      end
   end

   // Pick the head-row element currently being presented
   always_comb begin
      sel_elem = '0;
      case (elem_idx)
         2'd0:    sel_elem = head.r0;
         2'd1:    sel_elem = head.r1;
         default: sel_elem = head.r2;
      endcase
   end

   // Outputs are gated by o_vld so an empty or resetting block presents zeros
   assign o_data = o_vld ? sel_elem[DATA_WIDTH-1:0] : '0;
   assign o_eor  = o_vld & (elem_idx == LAST_ELEM);
   assign o_eom  = o_eor & (row_idx == LAST_ROW);
   assign o_of   = o_eom & (ovf_acc | head.of);

endmodule

// File: tb/tb_mapu_row_ser.sv
// tb/tb_mapu_row_ser.sv - directed self-checking bench for mapu_row_ser
module tb_mapu_row_ser;

   logic        clk;
   logic        reset_n;
   logic        i_en;
   logic        i_vld;
   logic [31:0] i_r0;
   logic [31:0] i_r1;
   logic [31:0] i_r2;
   logic        i_of;
   logic        o_rdy;
   logic        o_vld;
   logic [31:0] o_data;
   logic        o_eor;
   logic        o_eom;
   logic        o_of;
   logic        i_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        en;
      logic        vld;
      logic [31:0] r0;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        of;
      logic        rdy;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_eor;
      logic        e_eom;
      logic        e_of;
   } vec_t;

   vec_t tbl[$];

   mapu_row_ser #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (i_en),
      .i_vld   (i_vld),
      .i_r0    (i_r0),
      .i_r1    (i_r1),
      .i_r2    (i_r2),
      .i_of    (i_of),
      .o_rdy   (o_rdy),
      .o_vld   (o_vld),
      .o_data  (o_data),
      .o_eor   (o_eor),
      .o_eom   (o_eom),
      .o_of    (o_of),
      .i_rdy   (i_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic vld, input logic [31:0] r0, input logic [31:0] r1,
                      input logic [31:0] r2, input logic of, input logic rdy, input logic e_rdy,
                      input logic e_vld, input logic [31:0] e_data, input logic e_eor,
                      input logic e_eom, input logic e_of);
      vec_t v;
      v.en = en; v.vld = vld; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.of = of; v.rdy = rdy;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data;
      v.e_eor = e_eor; v.e_eom = e_eom; v.e_of = e_of;
      tbl.push_back(v);
   endtask

   // Full matrix, i_rdy=1: rows b+1.., third row held until FIFO has room
   task automatic add_matrix(input int b, input logic of0, input logic of1, input logic of2);
      logic [31:0] q;
      q = 32'(b);
      add(1, 1, q+1, q+2, q+3, of0, 1, 1, 0, 0,   0, 0, 0);
      add(1, 1, q+4, q+5, q+6, of1, 1, 1, 1, q+1, 0, 0, 0);
      add(1, 1, q+7, q+8, q+9, of2, 1, 0, 1, q+2, 0, 0, 0);
      add(1, 1, q+7, q+8, q+9, of2, 1, 0, 1, q+3, 1, 0, 0);
      add(1, 1, q+7, q+8, q+9, of2, 1, 1, 1, q+4, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, q+5, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, q+6, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, q+7, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, q+8, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, q+9, 1, 1, of0 | of1 | of2);
      add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0);
   endtask

   // Drive each vector at negedge, compare just after, consume the table
   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         i_en = tbl[i].en; i_vld = tbl[i].vld; i_r0 = tbl[i].r0; i_r1 = tbl[i].r1;
         i_r2 = tbl[i].r2; i_of = tbl[i].of; i_rdy = tbl[i].rdy;
         #1;
         check($sformatf("%s[%0d].o_rdy", tag, i), 32'(o_rdy), 32'(tbl[i].e_rdy));
         check($sformatf("%s[%0d].o_vld", tag, i), 32'(o_vld), 32'(tbl[i].e_vld));
         check($sformatf("%s[%0d].o_eor", tag, i), 32'(o_eor), 32'(tbl[i].e_eor));
         check($sformatf("%s[%0d].o_eom", tag, i), 32'(o_eom), 32'(tbl[i].e_eom));
         if (tbl[i].e_vld)
            check($sformatf("%s[%0d].o_data", tag, i), o_data, tbl[i].e_data);
         if (tbl[i].e_eom)
            check($sformatf("%s[%0d].o_of", tag, i), 32'(o_of), 32'(tbl[i].e_of));
      end
      tbl.delete();
   endtask

   initial begin
      reset_n = 1'b0; i_en = 1'b1; i_vld = 1'b0; i_r0 = '0; i_r1 = '0; i_r2 = '0;
      i_of = 1'b0; i_rdy = 1'b1;
      #1;
      check("reset.o_rdy", 32'(o_rdy), 0);
      check("reset.o_vld", 32'(o_vld), 0);
      check("reset.o_data", o_data, 0);
      check("reset.o_eom", 32'(o_eom), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_reset.o_rdy", 32'(o_rdy), 1);

      // Back-to-back matrix 1..9
      add_matrix(0, 0, 0, 0);
      run_tbl("stream");

      // Downstream stall of 4 cycles on element 2
      add(1, 1, 1, 2, 3, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 4, 5, 6, 0, 1, 1, 1, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++)
         add(1, 1, 7, 8, 9, 0, 0, 0, 1, 2, 0, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 0, 1, 2, 0, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 0, 1, 3, 1, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 1, 1, 4, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 6, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 9, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      run_tbl("stall");

      // Overflow on the middle row, then clean matrix; then on the last row, then clean
      add_matrix(0, 0, 1, 0);
      add_matrix(0, 0, 0, 0);
      add_matrix(18, 0, 0, 1);
      add_matrix(27, 0, 0, 0);
      run_tbl("ovf");

      // Enable dropped after row 1; buffered row drains, overflow on row 0 survives
      add(1, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 4, 5, 6, 0, 1, 0, 1, 1, 0, 0, 0);
      add(0, 1, 4, 5, 6, 0, 1, 0, 1, 2, 0, 0, 0);
      add(0, 1, 4, 5, 6, 0, 1, 0, 1, 3, 1, 0, 0);
      add(0, 1, 4, 5, 6, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 4, 5, 6, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 1, 1, 4, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 6, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 9, 1, 1, 1);
      add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      run_tbl("enable");

      // Count=1 with accept and pop on the same edge
      add(1, 1, 1, 2, 3, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0);
      add(1, 1, 4, 5, 6, 0, 1, 1, 1, 3, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 4, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 6, 1, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 9, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      run_tbl("same_edge");

      // Mid-matrix reset while element 5 is presented; row 0 carried overflow
      add(1, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 4, 5, 6, 0, 1, 1, 1, 1, 0, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 0, 1, 2, 0, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 0, 1, 3, 1, 0, 0);
      add(1, 1, 7, 8, 9, 0, 1, 1, 1, 4, 0, 0, 0);
      run_tbl("pre_reset");
      @(negedge clk);
      i_vld = 1'b0;
      #1;
      check("mid.o_data", o_data, 5);
      reset_n = 1'b0;
      #1;
      check("mid_reset.o_vld", 32'(o_vld), 0);
      check("mid_reset.o_rdy", 32'(o_rdy), 0);
      check("mid_reset.o_data", o_data, 0);
      check("mid_reset.o_eor", 32'(o_eor), 0);
      @(negedge clk);
      reset_n = 1'b1;
      add_matrix(9, 0, 0, 0);
      run_tbl("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
